// File: rtl/spi_uart_fifo_if.sv
// rtl/spi_uart_fifo_if.sv - SPI-side word input, UART handshake and FIFO status bundle.
interface spi_uart_fifo_if #(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_W     = 3
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_start;
   logic                  tx_done;
   logic [ADDR_W:0]       count;
   logic                  full;
   logic                  empty;
   logic                  overflow;

   modport master (
      output in_data, in_valid, tx_done,
      input  tx_data, tx_start, count, full, empty, overflow
   );

   modport slave (
      input  in_data, in_valid, tx_done,
      output tx_data, tx_start, count, full, empty, overflow
   );
endinterface

// File: rtl/spi_uart_fifo.sv
// rtl/spi_uart_fifo.sv - Resynchronises SPI words into a circular FIFO and feeds the UART one word per start/done handshake.
module spi_uart_fifo #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 8,
   parameter int ADDR_W     = 3
) (
   input logic            clk,
   input logic            rst_n,
   spi_uart_fifo_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic                  s1_valid_q, s2_valid_q, s3_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]       count_q, count_d;
   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  overflow_q;

   logic full_w, empty_w, wr_req, pop, wr_en, drop;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);
   assign wr_req  = s2_valid_q & ~s3_valid_q;
   assign pop     = (state_q == ST_IDLE) && !empty_w;
   // A full FIFO still takes the word when the head leaves on the same edge.
   assign wr_en   = wr_req && (!full_w || pop);
   assign drop    = wr_req && full_w && !pop;

   always_comb begin
      count_d = count_q;
      if (wr_en && !pop)
         count_d = count_q + CNT_ONE;
      else if (!wr_en && pop)
         count_d = count_q - CNT_ONE;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!empty_w) state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (bus.tx_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= s2_data_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_data_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         s1_valid_q <= bus.in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
         s1_data_q  <= bus.in_data;
         s2_data_q  <= s1_data_q;
         count_q    <= count_d;
         state_q    <= state_d;
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            tx_data_q <= mem_q[rd_ptr_q];
         end
         if (drop)
            overflow_q <= 1'b1;
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = (state_q == ST_START);
   assign bus.count    = count_q;
   assign bus.full     = full_w;
   assign bus.empty    = empty_w;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_spi_uart_fifo.sv
// tb/tb_spi_uart_fifo.sv - Randomised scenario bench for spi_uart_fifo against a queue-based reference.
module tb_spi_uart_fifo;
   localparam int DW    = 10;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   int   auto_done;
   int   done_delay;

   logic [DW-1:0] sent_q[$];
   int            start_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] w [12];

   spi_uart_fifo_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

   spi_uart_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmit monitor: every cycle with tx_start high is one frame request.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            sent_q.push_back(bus.tx_data);
            start_q.push_back(cyc);
         end
      end
   end

   // UART stand-in: answers each start with a one-cycle done after done_delay cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1 && auto_done != 0) begin
            repeat (done_delay) @(negedge clk);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
         end
      end
   end

   task automatic write_word(input logic [DW-1:0] d);
      @(negedge clk);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int limit);
      for (int i = 0; i < limit && sent_q.size() < n; i++) @(negedge clk);
   endtask

   task automatic fill_words(input int n);
      for (int i = 0; i < n; i++) w[i] = DW'($urandom_range(1, (1 << DW) - 1));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = ~bus.in_valid;
         bus.in_data  = DW'($urandom);
      end
      @(negedge clk);
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
      total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
      total++; if (bus.tx_data !== '0) begin bad++; $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_no_write: got count %0d want 0", bus.count); end
   endtask

   task automatic test_single();
      auto_done = 0;
      sent_q.delete();
      @(negedge clk);
      bus.in_data  = 10'h2A5;
      bus.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (bus.count !== 4'd1 || bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_write_latency: got count %0d start %b want 1 0", bus.count, bus.tx_start); end
      @(negedge clk);
      total++; if (bus.count !== 4'd0 || bus.tx_start !== 1'b1) begin bad++; $display("FAIL single_pop_latency: got count %0d start %b want 0 1", bus.count, bus.tx_start); end
      total++; if (bus.tx_data !== 10'h2A5) begin bad++; $display("FAIL single_data: got %h want 2a5", bus.tx_data); end
      @(negedge clk);
      total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b want 0", bus.tx_start); end
      bus.in_valid = 1'b0;
      repeat (40) @(negedge clk);
      total++; if (sent_q.size() !== 1) begin bad++; $display("FAIL single_one_start: got %0d want 1", sent_q.size()); end
      total++; if (bus.tx_data !== 10'h2A5) begin bad++; $display("FAIL single_hold: got %h want 2a5", bus.tx_data); end
      pulse_done();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_release();
      logic [DW-1:0] d;
      d = DW'($urandom_range(1, 1023));
      auto_done = 0;
      sent_q.delete();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      total++; if (sent_q.size() !== 1) begin bad++; $display("FAIL release_write_count: got %0d want 1", sent_q.size()); end
      else begin
         total++; if (sent_q[0] !== d) begin bad++; $display("FAIL release_write_data: got %h want %h", sent_q[0], d); end
      end
      pulse_done();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_order_wrap();
      fill_words(12);
      sent_q.delete();
      exp_q.delete();
      done_delay = 20;
      auto_done  = 1;
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(w[i]);
         write_word(w[i]);
         repeat (6) @(negedge clk);
      end
      wait_sent(12, 2000);
      repeat (40) @(negedge clk);
      auto_done = 0;
      total++; if (sent_q.size() !== 12) begin bad++; $display("FAIL order_count: got %0d want 12", sent_q.size()); end
      for (int i = 0; i < 12 && i < sent_q.size(); i++) begin
         total++; if (sent_q[i] !== exp_q[i]) begin bad++; $display("FAIL order_word%0d: got %h want %h", i, sent_q[i], exp_q[i]); end
      end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL order_overflow: got %b want 0", bus.overflow); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL order_empty: got %b want 1", bus.empty); end
   endtask

   task automatic test_back_to_back();
      fill_words(5);
      sent_q.delete();
      start_q.delete();
      auto_done = 0;
      for (int i = 0; i < 5; i++) write_word(w[i]);
      total++; if (bus.count !== 4'd4) begin bad++; $display("FAIL b2b_count: got %0d want 4", bus.count); end
      done_delay = 1;
      auto_done  = 1;
      pulse_done();
      wait_sent(5, 200);
      repeat (10) @(negedge clk);
      auto_done = 0;
      total++; if (start_q.size() !== 5) begin bad++; $display("FAIL b2b_starts: got %0d want 5", start_q.size()); end
      for (int i = 2; i < 5 && i < start_q.size(); i++) begin
         total++; if (start_q[i] - start_q[i-1] !== 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 3", i, start_q[i] - start_q[i-1]); end
      end
      for (int i = 0; i < 5 && i < sent_q.size(); i++) begin
         total++; if (sent_q[i] !== w[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, sent_q[i], w[i]); end
      end
   endtask

   task automatic test_overflow();
      int stored;
      fill_words(10);
      sent_q.delete();
      exp_q.delete();
      auto_done = 0;
      // Model: first word goes straight into flight, later ones queue until DEPTH, the rest drop.
      stored = 0;
      for (int i = 1; i < 10; i++) begin
         if (stored < DEPTH) begin
            exp_q.push_back(w[i]);
            stored++;
         end
      end
      for (int i = 0; i < 9; i++) write_word(w[i]);
      total++; if (bus.full !== 1'b1 || bus.count !== 4'(DEPTH)) begin bad++; $display("FAIL ovf_full: got full %b count %0d want 1 %0d", bus.full, bus.count, DEPTH); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
      write_word(w[9]);
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
      total++; if (bus.count !== 4'(stored)) begin bad++; $display("FAIL ovf_count: got %0d want %0d", bus.count, stored); end
      total++; if (sent_q.size() !== 1 || sent_q[0] !== w[0]) begin bad++; $display("FAIL ovf_inflight: got n=%0d want first %h", sent_q.size(), w[0]); end
      done_delay = $urandom_range(1, 5);
      auto_done  = 1;
      pulse_done();
      wait_sent(1 + stored, 500);
      repeat (40) @(negedge clk);
      auto_done = 0;
      total++; if (sent_q.size() !== 1 + stored) begin bad++; $display("FAIL ovf_sent: got %0d want %0d", sent_q.size(), 1 + stored); end
      for (int i = 0; i < stored && i + 1 < sent_q.size(); i++) begin
         total++; if (sent_q[i+1] !== exp_q[i]) begin bad++; $display("FAIL ovf_word%0d: got %h want %h", i, sent_q[i+1], exp_q[i]); end
      end
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
   endtask

   task automatic test_simul_full();
      fill_words(10);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sent_q.delete();
      auto_done = 0;
      for (int i = 0; i < 9; i++) write_word(w[i]);
      total++; if (bus.count !== 4'(DEPTH)) begin bad++; $display("FAIL simul_pre_count: got %0d want %0d", bus.count, DEPTH); end
      // Word 10 lands on the edge where word 2 is popped.
      @(negedge clk);
      bus.in_data  = w[9];
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      @(negedge clk);
      total++; if (bus.tx_start !== 1'b1 || bus.tx_data !== w[1]) begin bad++; $display("FAIL simul_pop: got start %b data %h want 1 %h", bus.tx_start, bus.tx_data, w[1]); end
      total++; if (bus.count !== 4'(DEPTH)) begin bad++; $display("FAIL simul_count: got %0d want %0d", bus.count, DEPTH); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL simul_overflow: got %b want 0", bus.overflow); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      done_delay = 2;
      auto_done  = 1;
      pulse_done();
      wait_sent(10, 500);
      repeat (20) @(negedge clk);
      auto_done = 0;
      total++; if (sent_q.size() !== 10) begin bad++; $display("FAIL simul_sent: got %0d want 10", sent_q.size()); end
      for (int i = 0; i < 10 && i < sent_q.size(); i++) begin
         total++; if (sent_q[i] !== w[i]) begin bad++; $display("FAIL simul_word%0d: got %h want %h", i, sent_q[i], w[i]); end
      end
   endtask

   task automatic test_reset_mid();
      fill_words(6);
      sent_q.delete();
      auto_done = 0;
      for (int i = 0; i < 6; i++) write_word(w[i]);
      total++; if (bus.count !== 4'd5) begin bad++; $display("FAIL mid_pre_count: got %0d want 5", bus.count); end
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      total++; if (sent_q.size() !== 1) begin bad++; $display("FAIL mid_no_resend: got %0d starts want 1", sent_q.size()); end
      total++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL mid_cleared: got count %0d empty %b want 0 1", bus.count, bus.empty); end
      total++; if (bus.tx_data !== '0) begin bad++; $display("FAIL mid_tx_data: got %h want 0", bus.tx_data); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      cyc          = 0;
      auto_done    = 0;
      done_delay   = 1;
      rst_n        = 1'b0;
      bus.in_data  = '0;
      bus.in_valid = 1'b0;
      bus.tx_done  = 1'b0;
      test_reset();
      test_single();
      test_reset_release();
      test_order_wrap();
      test_back_to_back();
      test_overflow();
      test_simul_full();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
